// File: rtl/mby_msh_pkg.sv
// Mesh-wide shared types and sizing for the column write path.
package mby_msh_pkg;

   localparam int NUM_MSH_PLANES = 2;

   // Column write request header carried alongside the data bus.
   typedef struct packed {
      logic [3:0]  id;
      logic [15:0] addr;
   } msh_col_wr_req_t;

   // Mesh data bus word.
   typedef logic [31:0] msh_dbus_t;

endpackage : mby_msh_pkg

// File: rtl/mby_msh_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// the pointer; the pointer moves to winner+1 only when advance is high.
module mby_msh_rr_arb #(
   parameter int N = 4
) (
   input  logic         mclk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          found;

   // Search from the pointer, wrapping, and remember where the next search starts.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         logic [PW:0]   sum;
         logic [PW-1:0] idx;
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d    = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
         end
      end
   end

   // Pointer only moves on an actual grant so a blocked plane keeps its priority order.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= ptr_d;
      end
   end

endmodule : mby_msh_rr_arb

// File: rtl/mby_msh_col_wr_arb.sv
// Column write arbiter: per mesh plane, round-robin among clients aiming at
// that plane, gated by a credit pool and a plane enable; the winner's
// header/data are registered onto the plane output one cycle later.
//
// Handshake: a client transfer happens in a cycle where i_cli_vld[c] and
// o_cli_rdy[c] are both high. o_cli_rdy is combinational from this cycle's
// inputs and state; a client must hold request/data stable until accepted.
// o_wr_vld is a one-cycle pulse per transfer with no back-pressure; flow
// control toward the mesh is by credits only.
module mby_msh_col_wr_arb
   import mby_msh_pkg::*;
#(
   parameter  int NUM_PLANES  = NUM_MSH_PLANES,
   parameter  int NUM_CLIENTS = 4,
   parameter  int MAX_CRDT    = 8,
   localparam int PLANE_W     = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1,
   localparam int CRDT_W      = $clog2(MAX_CRDT + 1)
) (
   input  logic                                   mclk,
   input  logic                                   rst_n,
   input  logic [NUM_CLIENTS-1:0]                 i_cli_vld,
   input  logic [NUM_CLIENTS-1:0][PLANE_W-1:0]    i_cli_plane,
   input  msh_col_wr_req_t [NUM_CLIENTS-1:0]      i_cli_req,
   input  msh_dbus_t [NUM_CLIENTS-1:0]            i_cli_dbus,
   output logic [NUM_CLIENTS-1:0]                 o_cli_rdy,
   input  logic [NUM_PLANES-1:0]                  i_plane_en,
   output logic [NUM_PLANES-1:0]                  o_wr_vld,
   output msh_col_wr_req_t [NUM_PLANES-1:0]       o_wr_req,
   output msh_dbus_t [NUM_PLANES-1:0]             o_wr_dbus,
   input  logic [NUM_PLANES-1:0]                  i_crdt_rtn_for_wr_req,
   output logic [NUM_PLANES-1:0][CRDT_W-1:0]      o_crdt_cnt,
   output logic [NUM_PLANES-1:0]                  o_crdt_err
);

   logic [NUM_PLANES-1:0][NUM_CLIENTS-1:0] plane_gnt;

   for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
      logic [NUM_CLIENTS-1:0] req_vec;
      logic [NUM_CLIENTS-1:0] gnt_raw;
      logic                   can_grant;
      logic                   grant;
      msh_col_wr_req_t        req_mux;
      msh_dbus_t              dbus_mux;
      logic                   vld_q;
      msh_col_wr_req_t        req_q;
      msh_dbus_t              dbus_q;
      logic [CRDT_W-1:0]      crdt_q;
      logic                   err_q;

      // Clients targeting a plane index >= NUM_PLANES never match any plane.
      for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_match
         assign req_vec[c] = i_cli_vld[c] && (i_cli_plane[c] == PLANE_W'(p));
      end

      // Credit check uses the registered count, so a same-cycle return cannot unblock a grant.
      assign can_grant = rst_n && i_plane_en[p] && (crdt_q != '0);

      mby_msh_rr_arb #(
         .N (NUM_CLIENTS)
      ) u_rr_arb (
         .mclk    (mclk),
         .rst_n   (rst_n),
         .req     (req_vec),
         .advance (grant),
         .gnt     (gnt_raw)
      );

      assign plane_gnt[p] = can_grant ? gnt_raw : '0;
      assign grant        = |plane_gnt[p];

      // Select the winning client's header and data.
      always_comb begin
         req_mux  = '0;
         dbus_mux = '0;
         for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (plane_gnt[p][c]) begin
               req_mux  = i_cli_req[c];
               dbus_mux = i_cli_dbus[c];
            end
         end
      end

      // Register the granted transfer; payload holds its last value when idle.
      always_ff @(posedge mclk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= 1'b0;
            req_q  <= '0;
            dbus_q <= '0;
         end else begin
            vld_q <= grant;
            if (grant) begin
               req_q  <= req_mux;
               dbus_q <= dbus_mux;
            end
         end
      end

      // Credit pool: grant consumes, return refills, both together cancel; overflow is sticky.
      always_ff @(posedge mclk or negedge rst_n) begin
         if (!rst_n) begin
            crdt_q <= CRDT_W'(MAX_CRDT);
            err_q  <= 1'b0;
         end else begin
            case ({grant, i_crdt_rtn_for_wr_req[p]})
               2'b10:   crdt_q <= crdt_q - CRDT_W'(1);
               2'b01: begin
                  if (crdt_q == CRDT_W'(MAX_CRDT)) begin
                     err_q <= 1'b1;
                  end else begin
                     crdt_q <= crdt_q + CRDT_W'(1);
                  end
               end
               default: crdt_q <= crdt_q;
            endcase
         end
      end

      assign o_wr_vld[p]   = vld_q;
      assign o_wr_req[p]   = req_q;
      assign o_wr_dbus[p]  = dbus_q;
      assign o_crdt_cnt[p] = crdt_q;
      assign o_crdt_err[p] = err_q;
   end

   // A client aims at one plane, so OR-ing the per-plane grants gives its ready.
   always_comb begin
      o_cli_rdy = '0;
      for (int p = 0; p < NUM_PLANES; p++) begin
         o_cli_rdy = o_cli_rdy | plane_gnt[p];
      end
   end

endmodule : mby_msh_col_wr_arb

// File: tb/tb_mby_msh_col_wr_arb.sv
// Bench for mby_msh_col_wr_arb: directed scenarios plus random traffic,
// checked against a per-plane reference model and an expected-output queue.
module tb_mby_msh_col_wr_arb;
   import mby_msh_pkg::*;

   localparam int NP   = NUM_MSH_PLANES;
   localparam int NC   = 4;
   localparam int MAXC = 8;
   localparam int PW   = 1;
   localparam int CW   = $clog2(MAXC + 1);

   typedef struct packed {
      logic            vld;
      msh_col_wr_req_t req;
      msh_dbus_t       dbus;
      logic [CW-1:0]   cnt;
      logic            err;
   } pl_exp_t;

   localparam int EXP_W = NP * $bits(pl_exp_t);

   // ---------------- clock / reset / DUT ----------------
   logic                           mclk;
   logic                           rst_n;
   logic [NC-1:0]                  i_cli_vld;
   logic [NC-1:0][PW-1:0]          i_cli_plane;
   msh_col_wr_req_t [NC-1:0]       i_cli_req;
   msh_dbus_t [NC-1:0]             i_cli_dbus;
   logic [NC-1:0]                  o_cli_rdy;
   logic [NP-1:0]                  i_plane_en;
   logic [NP-1:0]                  o_wr_vld;
   msh_col_wr_req_t [NP-1:0]       o_wr_req;
   msh_dbus_t [NP-1:0]             o_wr_dbus;
   logic [NP-1:0]                  i_crdt_rtn;
   logic [NP-1:0][CW-1:0]          o_crdt_cnt;
   logic [NP-1:0]                  o_crdt_err;

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   mby_msh_col_wr_arb #(
      .NUM_PLANES  (NP),
      .NUM_CLIENTS (NC),
      .MAX_CRDT    (MAXC)
   ) dut (
      .mclk                  (mclk),
      .rst_n                 (rst_n),
      .i_cli_vld             (i_cli_vld),
      .i_cli_plane           (i_cli_plane),
      .i_cli_req             (i_cli_req),
      .i_cli_dbus            (i_cli_dbus),
      .o_cli_rdy             (o_cli_rdy),
      .i_plane_en            (i_plane_en),
      .o_wr_vld              (o_wr_vld),
      .o_wr_req              (o_wr_req),
      .o_wr_dbus             (o_wr_dbus),
      .i_crdt_rtn_for_wr_req (i_crdt_rtn),
      .o_crdt_cnt            (o_crdt_cnt),
      .o_crdt_err            (o_crdt_err)
   );

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               n_cmp;
   int               n_bad;
   logic [NC-1:0]    last_rdy;

   // Reference model: credits, sticky error, rotation start, last payload.
   int               m_cred [NP];
   bit               m_err  [NP];
   int               m_ptr  [NP];
   msh_col_wr_req_t  m_req  [NP];
   msh_dbus_t        m_dbus [NP];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_cred[p] = MAXC;
         m_err[p]  = 1'b0;
         m_ptr[p]  = 0;
         m_req[p]  = '0;
         m_dbus[p] = '0;
      end
   endtask

   // ---------------- driver tasks ----------------
   // One cycle of stimulus: drive at the falling edge, predict, check ready,
   // and queue what the plane outputs must show after the next rising edge.
   task automatic step(input logic [NC-1:0] vld, input logic [NC-1:0] pl,
                       input logic [NP-1:0] en, input logic [NP-1:0] ret);
      logic [NC-1:0]    exp_rdy;
      pl_exp_t [NP-1:0] ent;
      @(negedge mclk);
      i_cli_vld  = vld;
      i_plane_en = en;
      i_crdt_rtn = ret;
      for (int c = 0; c < NC; c++) begin
         i_cli_plane[c] = pl[c];
         i_cli_req[c]   = msh_col_wr_req_t'($urandom);
         i_cli_dbus[c]  = msh_dbus_t'($urandom);
      end
      #1;
      exp_rdy = '0;
      for (int p = 0; p < NP; p++) begin
         int win;
         bit g;
         bit r;
         win = -1;
         if (en[p] && m_cred[p] > 0) begin
            for (int k = 0; k < NC; k++) begin
               int c;
               c = (m_ptr[p] + k) % NC;
               if (win < 0 && vld[c] && int'(pl[c]) == p) win = c;
            end
         end
         g = (win >= 0);
         r = ret[p];
         if (g) begin
            exp_rdy   = exp_rdy | (NC'(1) << win);
            m_ptr[p]  = (win + 1) % NC;
            m_req[p]  = i_cli_req[win];
            m_dbus[p] = i_cli_dbus[win];
         end
         if (g && !r) begin
            m_cred[p] = m_cred[p] - 1;
         end else if (r && !g) begin
            if (m_cred[p] == MAXC) m_err[p] = 1'b1;
            else m_cred[p] = m_cred[p] + 1;
         end
         ent[p].vld  = g;
         ent[p].req  = m_req[p];
         ent[p].dbus = m_dbus[p];
         ent[p].cnt  = CW'(m_cred[p]);
         ent[p].err  = m_err[p];
      end
      check("cli_rdy", 64'(o_cli_rdy), 64'(exp_rdy));
      last_rdy = o_cli_rdy;
      exp_q.push_back(ent);
   endtask

   // Wait past the rising edge that commits the last step (after the monitor).
   task automatic peek();
      @(posedge mclk);
      #2;
   endtask

   task automatic apply_reset();
      @(negedge mclk);
      rst_n     = 1'b0;
      i_cli_vld = '1;
      #1;
      check("rst_wr_vld", 64'(o_wr_vld), 64'(0));
      check("rst_cli_rdy", 64'(o_cli_rdy), 64'(0));
      for (int p = 0; p < NP; p++) begin
         check("rst_crdt_cnt", 64'(o_crdt_cnt[p]), 64'(MAXC));
         check("rst_crdt_err", 64'(o_crdt_err[p]), 64'(0));
         check("rst_wr_req", 64'(o_wr_req[p]), 64'(0));
         check("rst_wr_dbus", 64'(o_wr_dbus[p]), 64'(0));
      end
      i_cli_vld  = '0;
      i_crdt_rtn = '0;
      exp_q.delete();
      model_reset();
      repeat (2) @(negedge mclk);
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      pl_exp_t [NP-1:0] e;
      forever begin
         @(posedge mclk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < NP; p++) begin
               check("wr_vld", 64'(o_wr_vld[p]), 64'(e[p].vld));
               check("wr_req", 64'(o_wr_req[p]), 64'(e[p].req));
               check("wr_dbus", 64'(o_wr_dbus[p]), 64'(e[p].dbus));
               check("crdt_cnt", 64'(o_crdt_cnt[p]), 64'(e[p].cnt));
               check("crdt_err", 64'(o_crdt_err[p]), 64'(e[p].err));
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus sequence ----------------
   initial begin
      logic [NC-1:0] ord [6];
      n_cmp       = 0;
      n_bad       = 0;
      last_rdy    = '0;
      rst_n       = 1'b1;
      i_cli_vld   = '0;
      i_cli_plane = '0;
      i_cli_req   = '0;
      i_cli_dbus  = '0;
      i_plane_en  = '1;
      i_crdt_rtn  = '0;
      model_reset();
      #2 rst_n = 1'b0;
      apply_reset();

      // Return into a full pool: count saturates, error sticks until reset.
      step('0, '0, 2'b11, 2'b01);
      peek();
      check("full_rtn_cnt", 64'(o_crdt_cnt[0]), 64'(MAXC));
      check("full_rtn_err", 64'(o_crdt_err[0]), 64'(1));
      repeat (3) step('0, '0, 2'b11, 2'b00);
      peek();
      check("err_sticky", 64'(o_crdt_err[0]), 64'(1));
      apply_reset();

      // Client 0 streams to plane 0 with no returns: exactly MAXC grants.
      for (int i = 0; i < MAXC; i++) begin
         step(4'b0001, 4'b0000, 2'b11, 2'b00);
         check("stream_rdy", 64'(last_rdy[0]), 64'(1));
      end
      step(4'b0001, 4'b0000, 2'b11, 2'b00);
      check("stream_rdy_empty", 64'(last_rdy[0]), 64'(0));
      peek();
      check("stream_cnt_zero", 64'(o_crdt_cnt[0]), 64'(0));

      // Empty pool: a return does not enable a same-cycle grant.
      step(4'b0001, 4'b0000, 2'b11, 2'b01);
      check("zero_rtn_no_gnt", 64'(last_rdy[0]), 64'(0));
      step(4'b0001, 4'b0000, 2'b11, 2'b00);
      check("zero_rtn_next_gnt", 64'(last_rdy[0]), 64'(1));
      step('0, '0, 2'b11, 2'b00);
      peek();
      check("zero_rtn_cnt", 64'(o_crdt_cnt[0]), 64'(0));

      // Round-robin order among clients 0, 1, 3 from a fresh pointer.
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(4'b1011, 4'b0000, 2'b11, 2'b00);
         ord[i] = last_rdy;
      end
      for (int i = 0; i < 6; i++) begin
         logic [NC-1:0] want;
         case (i % 3)
            0:       want = 4'b0001;
            1:       want = 4'b0010;
            default: want = 4'b1000;
         endcase
         check("rr_order", 64'(ord[i]), 64'(want));
      end

      // Plane 1 at credit 3: grant and return together leave the count unchanged.
      apply_reset();
      repeat (5) step(4'b0010, 4'b0010, 2'b11, 2'b00);
      step(4'b0010, 4'b0010, 2'b11, 2'b10);
      peek();
      check("gnt_rtn_cnt", 64'(o_crdt_cnt[1]), 64'(3));
      check("gnt_rtn_vld", 64'(o_wr_vld[1]), 64'(1));

      // Reset while a write is on the outputs, then a disabled plane stays silent.
      apply_reset();
      repeat (6) step(4'b0001, 4'b0000, 2'b11, 2'b00);
      peek();
      check("pre_rst_vld", 64'(o_wr_vld[0]), 64'(1));
      check("pre_rst_cnt", 64'(o_crdt_cnt[0]), 64'(2));
      apply_reset();
      repeat (4) begin
         step(4'b0010, 4'b0010, 2'b01, 2'b00);
         check("plane_dis_rdy", 64'(last_rdy), 64'(0));
      end

      // Random traffic: mixed targets, enables and credit returns.
      for (int i = 0; i < 400; i++) begin
         logic [NP-1:0] en;
         logic [NP-1:0] ret;
         for (int p = 0; p < NP; p++) begin
            en[p]  = ($urandom_range(0, 4) != 0);
            ret[p] = ($urandom_range(0, 9) < 3);
         end
         step(NC'($urandom), NC'($urandom), en, ret);
      end

      repeat (3) step('0, '0, 2'b11, 2'b00);
      peek();
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mby_msh_col_wr_arb

// File: doc/mby_msh_col_wr_arb.md
MBY_MSH_COL_WR_ARB -- requirements
Module: mby_msh_col_wr_arb

Interface
REQ-001 SHALL have parameter NUM_PLANES, default NUM_MSH_PLANES: number of mesh write planes.
REQ-002 SHALL have parameter NUM_CLIENTS, default 4: number of write clients, range 1..16.
REQ-003 SHALL have parameter MAX_CRDT, default 8: per-plane credit pool depth, range 1..63.
REQ-004 SHALL have port mclk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_cli_vld, input, [NUM_CLIENTS]: client write request valid.
REQ-007 SHALL have port i_cli_plane, input, [NUM_CLIENTS] x clog2(NUM_PLANES) (min 1): target plane.
REQ-008 SHALL have port i_cli_req, input, [NUM_CLIENTS] x msh_col_wr_req_t: request header.
REQ-009 SHALL have port i_cli_dbus, input, [NUM_CLIENTS] x msh_dbus_t: write data.
REQ-010 SHALL have port o_cli_rdy, output, [NUM_CLIENTS]: grant; transfer when vld and rdy are both high.
REQ-011 SHALL have port i_plane_en, input, [NUM_PLANES]: plane enable mask.
REQ-012 SHALL have port o_wr_vld, output, [NUM_PLANES]: mesh write valid per plane.
REQ-013 SHALL have port o_wr_req / o_wr_dbus, output, [NUM_PLANES] x msh_col_wr_req_t / msh_dbus_t: mesh request and data.
REQ-014 SHALL have port i_crdt_rtn_for_wr_req, input, [NUM_PLANES]: one credit returned per high cycle.
REQ-015 SHALL have port o_crdt_cnt, output, [NUM_PLANES] x CRDT_W, CRDT_W = clog2(MAX_CRDT+1): available credits.
REQ-016 SHALL have port o_crdt_err, output, [NUM_PLANES]: sticky credit-overflow flag.

Function
REQ-017 Per plane, SHALL arbitrate among clients with i_cli_vld high and i_cli_plane equal to that plane, using round-robin.
REQ-018 Round-robin pointer SHALL advance to the winner+1 (mod NUM_CLIENTS) only on a grant; after reset the pointer is 0 (client 0 highest priority).
REQ-019 A plane SHALL grant only if credit>0, the plane is enabled, and the plane is in range (plane >= NUM_PLANES is never granted).
REQ-020 At most one grant per plane per cycle; a client targets one plane, so it receives at most one grant.
REQ-021 o_cli_rdy SHALL be combinational from the current inputs and state; no registered bubble.
REQ-022 The granted request/data SHALL appear on o_wr_req/o_wr_dbus with o_wr_vld high exactly 1 cycle after the grant, registered.
REQ-023 o_wr_vld SHALL be low in cycles without a grant; o_wr_req/o_wr_dbus SHALL hold their last value when idle.
REQ-024 Credit update: grant only -> -1; return only -> +1; grant and return in the same cycle -> unchanged.
REQ-025 A return with credit == MAX_CRDT and no same-cycle grant SHALL saturate the count and set o_crdt_err, which stays set until reset.
REQ-026 With credit == 0, a same-cycle return SHALL NOT enable a grant; the grant waits one cycle.
REQ-027 Deasserting i_plane_en SHALL block new grants from the next evaluation; an in-flight registered output still issues, and credit returns are still counted.

Reset
REQ-028 On rst_n low, the block SHALL set o_wr_vld=0, o_wr_req=0, o_wr_dbus=0, o_crdt_cnt=MAX_CRDT, o_crdt_err=0, and RR pointers=0.
REQ-029 Reset mid-operation SHALL drop in-flight outputs and restore full credit; the sender of credits resets together with this block.
REQ-030 o_cli_rdy SHALL be 0 while rst_n is low.

Structure
REQ-031 msh_col_wr_req_t, msh_dbus_t, and NUM_MSH_PLANES SHALL come from mby_msh_pkg; no new package types are added.
REQ-032 Round-robin arbitration SHALL be a sub-module mby_msh_rr_arb (parameter N; inputs req and advance; outputs one-hot gnt), with one instance per plane.
REQ-033 Credit counters and output registers SHALL live in the top level, built with a generate loop per plane.

Verification
REQ-034 After reset with MAX_CRDT=8, client0 streams to plane0 with no returns -> 8 grants on consecutive cycles, o_wr_vld high cycles 1..8, o_cli_rdy[0]=0 from the 9th cycle, o_crdt_cnt[0]=0.
REQ-035 Clients 0, 1, and 3 request plane0 continuously with ample credit -> grant order 0,1,3,0,1,3; each output lags its grant by 1 cycle.
REQ-036 With credit=0, a return pulse while client0 is requesting -> no grant that cycle, grant next cycle, count returns to 0.
REQ-037 With credit=8 (full), a single return -> o_crdt_cnt stays 8 and o_crdt_err[0]=1 until rst_n is asserted.
REQ-038 Simultaneous grant and return on plane1 with credit=3 -> count stays 3 and o_wr_vld[1] is high next cycle.
REQ-039 rst_n asserted while o_wr_vld=1 and credit=2 -> immediately o_wr_vld=0 and o_crdt_cnt=8; after release, plane1 with i_plane_en[1]=0 receives no grants.
